mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
- Shares the 16-bit four-to-one mux datapath among four independent requesters, each with a valid/ready handshake.
- Round-robin arbitration selects one requester per accepted beat and drives the mux select with the grant index.
- The mux output is captured into a single registered output stage that has its own valid/ready handshake.
- Sits between four producer blocks and one downstream consumer.

Parameters:
- WIDTH, 16, data width of each requester and of the output. The mux datapath is 16 bits, so only 16 is legal.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset. Sampled on the rising edge of clk.
- in_valid  input  4  per-requester valid; bit i belongs to requester i.
- in_data0..in_data3  input  WIDTH each  requester payloads; feed mux inputs I0..I3.
- in_ready  output  4  one-hot (or zero) grant/accept strobe per requester.
- out_valid  output  1  registered output holds a beat.
- out_data  output  WIDTH  registered payload.
- out_src  output  2  index of the requester that produced out_data.
- out_ready  input  1  downstream accepts the beat when out_valid && out_ready.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - out_valid=0, out_data=0, out_src=0, last_grant=3. Requester 0 has highest priority first.
  - in_ready=0 while rst_n=0.
  - Reset mid-transfer discards any held beat; no handshake completes in that cycle.
- Output space: space = !out_valid || out_ready. A full register that drains in the same cycle may reload (full throughput).
- Arbitration (combinational, evaluated each cycle):
  - Search in_valid starting from index (last_grant+1) mod 4, wrapping, and pick the first set bit as g.
  - grant_any = |in_valid && space.
- in_ready:
  - in_ready[g]=1 only when grant_any; all other bits are 0.
  - in_ready never depends on in_data.
  - Requesters may hold in_valid indefinitely; they are never required to wait for in_ready before asserting valid.
- Mux select: S = g, driving the 4:1 mux. The mux output is the combinational source for the output register.
- On a clock edge with grant_any: out_data <= mux output, out_src <= g, out_valid <= 1, last_grant <= g.
- On a clock edge with out_valid && out_ready && !grant_any: out_valid <= 0. out_data and out_src keep their values.
- On a clock edge with out_valid && !out_ready: out_valid, out_data and out_src are held stable. No requester is granted.
- Latency: a requester's beat accepted in cycle N appears on out_data with out_valid in cycle N+1.
- Fairness: with all four valids held high and out_ready=1, grants rotate 0,1,2,3,0,... one per cycle. No requester waits more than 3 other grants.
- A single active requester is granted every cycle it is valid and space exists.
- State machine, 2 states:
  - EMPTY (out_valid=0) -> FULL on grant_any.
  - FULL -> EMPTY on out_ready && !grant_any.
  - FULL -> FULL on a simultaneous drain+load, or on a stall.
- last_grant updates only on a grant, never on a stall or an idle cycle.

Optional Feature:
- Macro: MUX4_ARB_BURST_EN.
- With the macro defined:
  - Adds input in_last[3:0].
  - Once requester g is granted a beat with in_last[g]=0, arbitration locks to g. Lock is held through stalls and through cycles with in_valid[g]=0.
  - Lock releases after the beat accepted with in_last[g]=1; round-robin then resumes from g+1.
  - Adds output out_last, registered alongside out_data.
  - Reset clears the lock.
- Without the macro: no in_last or out_last ports; every beat is arbitrated independently as described above.

Test Plan:
- Reset: hold rst_n=0 with in_valid=4'b1111 -> in_ready=0, out_valid=0, out_data=0. First cycle after release grants requester 0; next cycle out_data=in_data0 and out_src=0.
- Rotation: all valid, data 16'h0A0A/16'h1B1B/16'h2C2C/16'h3D3D, out_ready=1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3 with matching data, one beat per cycle.
- Backpressure: out_valid=1 holding 16'h1B1B, out_ready=0 for 3 cycles -> out_data and out_src stable, in_ready=0. Raising out_ready drains and reloads in the same cycle.
- Wrap/skip: last_grant=2, in_valid=4'b0011 -> requester 0 granted, then requester 1, then requester 0.
- Idle drain: single beat from requester 3 with 16'hBEEF, then in_valid=0, out_ready=1 -> out_valid drops after one cycle. A subsequent request from requester 3 still follows round-robin from last_grant=3.
- Burst (MUX4_ARB_BURST_EN): requester 1 sends 3 beats with in_last on the third while requester 2 is valid throughout -> out_src=1,1,1 then 2; out_last=1 on the third beat only.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Four valid/ready requesters share a 4:1 mux, round-robin arbitrated into one registered output stage.
// Optional burst locking (in_last/out_last) is enabled by defining MUX4_ARB_BURST_EN.
module mux4_rr_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       in_valid,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    input  logic [WIDTH-1:0] in_data3,
`ifdef MUX4_ARB_BURST_EN
    input  logic [3:0]       in_last,
`endif
    output logic [3:0]       in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_src,
`ifdef MUX4_ARB_BURST_EN
    output logic             out_last,
`endif
    input  logic             out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0]       last_grant;
    logic [1:0]       rr_grant;
    logic             rr_found;
    logic [1:0]       grant;
    logic             req_ok;
    logic             space;
    logic             grant_any;
    logic [WIDTH-1:0] mux_out;

    assign out_valid = (state == FULL);
    assign space     = (state == EMPTY) || out_ready;

    // Search starts one past the last winner and wraps, so offset 4 revisits last_grant itself.
    always_comb begin
        rr_grant = last_grant;
        rr_found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!rr_found && in_valid[last_grant + 2'(k)]) begin
                rr_grant = last_grant + 2'(k);
                rr_found = 1'b1;
            end
        end
    end

`ifdef MUX4_ARB_BURST_EN
    logic locked;

    // While locked the burst owner is always last_grant, so it is reused as the lock index.
    assign grant  = locked ? last_grant : rr_grant;
    assign req_ok = locked ? in_valid[last_grant] : rr_found;
`else
    assign grant  = rr_grant;
    assign req_ok = rr_found;
`endif

    assign grant_any = rst_n && req_ok && space;

    always_comb begin
        in_ready = 4'b0000;
        if (grant_any) begin
            in_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        case (grant)
            2'd0:    mux_out = in_data0;
            2'd1:    mux_out = in_data1;
            2'd2:    mux_out = in_data2;
            default: mux_out = in_data3;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (grant_any) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (out_ready && !grant_any) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= EMPTY;
            out_data   <= '0;
            out_src    <= 2'd0;
            last_grant <= 2'd3;
        end else begin
            state <= state_next;
            if (grant_any) begin
                out_data   <= mux_out;
                out_src    <= grant;
                last_grant <= grant;
            end
        end
    end

`ifdef MUX4_ARB_BURST_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            locked   <= 1'b0;
            out_last <= 1'b0;
        end else if (grant_any) begin
            locked   <= !in_last[grant];
            out_last <= in_last[grant];
        end
    end
`endif

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios plus randomized traffic against a behavioural model.
// Burst checks are compiled in when MUX4_ARB_BURST_EN is defined.
module tb_mux4_rr_arbiter;
    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       in_valid;
    logic [WIDTH-1:0] dataArr [4];
    logic [WIDTH-1:0] rotData [4];
    logic [WIDTH-1:0] in_data0, in_data1, in_data2, in_data3;
    logic [3:0]       in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_src;
    logic             out_ready;
`ifdef MUX4_ARB_BURST_EN
    logic [3:0]       in_last;
    logic             out_last;
`endif

    int checks   = 0;
    int failures = 0;

    int               mLast;
    bit               mValid;
    logic [WIDTH-1:0] mData;
    int               mSrc;
    bit               mLocked;
    bit               mOutLast;
    int               mGrant;
    logic [3:0]       mExpReady;

    assign in_data0 = dataArr[0];
    assign in_data1 = dataArr[1];
    assign in_data2 = dataArr[2];
    assign in_data3 = dataArr[3];

    mux4_rr_arbiter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .in_data2  (in_data2),
        .in_data3  (in_data3),
`ifdef MUX4_ARB_BURST_EN
        .in_last   (in_last),
`endif
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
`ifdef MUX4_ARB_BURST_EN
        .out_last  (out_last),
`endif
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Winner is the first valid requester found walking forward from the previous winner.
    function automatic int pickGrant();
        if (mLocked) begin
            return in_valid[mLast] ? mLast : -1;
        end
        for (int k = 1; k <= 4; k++) begin
            automatic int idx = (mLast + k) % 4;
            if (in_valid[idx]) begin
                return idx;
            end
        end
        return -1;
    endfunction

    task automatic prep();
        automatic bit space;
        automatic int g;
        #1;
        space     = !mValid || out_ready;
        g         = pickGrant();
        mGrant    = (rst_n && space) ? g : -1;
        mExpReady = (mGrant >= 0) ? 4'(1 << mGrant) : 4'b0000;
    endtask

    task automatic applyStimulus(input logic [3:0] v, input logic r);
        in_valid  = v;
        out_ready = r;
        prep();
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            mValid   = 0;
            mData    = '0;
            mSrc     = 0;
            mLast    = 3;
            mLocked  = 0;
            mOutLast = 0;
        end else if (mGrant >= 0) begin
            mData  = dataArr[mGrant];
            mSrc   = mGrant;
            mValid = 1;
            mLast  = mGrant;
`ifdef MUX4_ARB_BURST_EN
            mOutLast = in_last[mGrant];
            mLocked  = !in_last[mGrant];
`endif
        end else if (mValid && out_ready) begin
            mValid = 0;
        end
        #1;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        applyStimulus(4'b0000, 1'b1);
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        applyStimulus(4'b1111, 1'b1);
        checks++;
        if (in_ready !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_in_ready got=%b exp=%b", in_ready, 4'b0000);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_src !== 2'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got=%b/%h/%0d exp=0/0000/0", out_valid, out_data, out_src);
        end
        rst_n = 1'b1;
        applyStimulus(4'b1111, 1'b1);
        checks++;
        if (in_ready !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL reset_first_grant got=%b exp=%b", in_ready, 4'b0001);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0A0A || out_src !== 2'd0) begin
            failures++;
            $display("[TB] FAIL reset_first_beat got=%b/%h/%0d exp=1/0a0a/0", out_valid, out_data, out_src);
        end
    endtask

    task automatic test_rotation();
        applyReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'b1111, 1'b1);
            checks++;
            if (in_ready !== 4'(1 << (i % 4))) begin
                failures++;
                $display("[TB] FAIL rotation_ready[%0d] got=%b exp=%b", i, in_ready, 4'(1 << (i % 4)));
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_src !== 2'(i % 4) || out_data !== rotData[i % 4]) begin
                failures++;
                $display("[TB] FAIL rotation_beat[%0d] got=%b/%0d/%h exp=1/%0d/%h",
                         i, out_valid, out_src, out_data, i % 4, rotData[i % 4]);
            end
        end
    endtask

    task automatic test_backpressure();
        applyReset();
        applyStimulus(4'b1111, 1'b1);
        tick();
        applyStimulus(4'b1111, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b1111, 1'b0);
            checks++;
            if (in_ready !== 4'b0000) begin
                failures++;
                $display("[TB] FAIL stall_ready[%0d] got=%b exp=0000", i, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'h1B1B || out_src !== 2'd1) begin
                failures++;
                $display("[TB] FAIL stall_hold[%0d] got=%b/%h/%0d exp=1/1b1b/1", i, out_valid, out_data, out_src);
            end
        end
        applyStimulus(4'b1111, 1'b1);
        checks++;
        if (in_ready !== 4'b0100) begin
            failures++;
            $display("[TB] FAIL drain_reload_ready got=%b exp=0100", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h2C2C || out_src !== 2'd2) begin
            failures++;
            $display("[TB] FAIL drain_reload_beat got=%b/%h/%0d exp=1/2c2c/2", out_valid, out_data, out_src);
        end
    endtask

    task automatic test_wrap_skip();
        logic [3:0] expReady [4];
        int         expSrc   [4];
        expReady[0] = 4'b0100; expSrc[0] = 2;
        expReady[1] = 4'b0001; expSrc[1] = 0;
        expReady[2] = 4'b0010; expSrc[2] = 1;
        expReady[3] = 4'b0001; expSrc[3] = 0;
        applyReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus((i == 0) ? 4'b0100 : 4'b0011, 1'b1);
            checks++;
            if (in_ready !== expReady[i]) begin
                failures++;
                $display("[TB] FAIL wrap_ready[%0d] got=%b exp=%b", i, in_ready, expReady[i]);
            end
            tick();
            checks++;
            if (out_src !== 2'(expSrc[i]) || out_data !== rotData[expSrc[i]]) begin
                failures++;
                $display("[TB] FAIL wrap_beat[%0d] got=%0d/%h exp=%0d/%h",
                         i, out_src, out_data, expSrc[i], rotData[expSrc[i]]);
            end
        end
    endtask

    task automatic test_idle_drain();
        applyReset();
        dataArr[3] = 16'hBEEF;
        applyStimulus(4'b1000, 1'b1);
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'hBEEF || out_src !== 2'd3) begin
            failures++;
            $display("[TB] FAIL idle_beat got=%b/%h/%0d exp=1/beef/3", out_valid, out_data, out_src);
        end
        applyStimulus(4'b0000, 1'b1);
        checks++;
        if (in_ready !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL idle_ready got=%b exp=0000", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'hBEEF || out_src !== 2'd3) begin
            failures++;
            $display("[TB] FAIL idle_drain got=%b/%h/%0d exp=0/beef/3", out_valid, out_data, out_src);
        end
        applyStimulus(4'b1001, 1'b1);
        checks++;
        if (in_ready !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL idle_rr_next got=%b exp=0001", in_ready);
        end
        tick();
        applyStimulus(4'b1001, 1'b1);
        checks++;
        if (in_ready !== 4'b1000) begin
            failures++;
            $display("[TB] FAIL idle_rr_after got=%b exp=1000", in_ready);
        end
        tick();
        dataArr[3] = rotData[3];
    endtask

`ifdef MUX4_ARB_BURST_EN
    task automatic test_burst();
        int expSrc  [4];
        bit expLast [4];
        expSrc[0] = 1; expSrc[1] = 1; expSrc[2] = 1; expSrc[3] = 2;
        expLast[0] = 0; expLast[1] = 0; expLast[2] = 1; expLast[3] = 0;
        applyReset();
        for (int i = 0; i < 4; i++) begin
            in_last = (i == 2) ? 4'b0010 : 4'b0000;
            applyStimulus(4'b0110, 1'b1);
            tick();
            checks++;
            if (out_src !== 2'(expSrc[i]) || out_last !== expLast[i]) begin
                failures++;
                $display("[TB] FAIL burst_beat[%0d] got=%0d/%b exp=%0d/%b",
                         i, out_src, out_last, expSrc[i], expLast[i]);
            end
        end
        in_last = 4'b1111;
        applyStimulus(4'b0100, 1'b1);
        tick();
        in_last = 4'b0000;
    endtask
`endif

    task automatic test_random();
        applyReset();
        for (int i = 0; i < 400; i++) begin
            for (int r = 0; r < 4; r++) begin
                dataArr[r] = 16'($urandom);
            end
            rst_n = ($urandom_range(0, 49) != 0);
`ifdef MUX4_ARB_BURST_EN
            in_last = 4'($urandom);
`endif
            applyStimulus(4'($urandom), ($urandom_range(0, 3) != 0));
            checks++;
            if (in_ready !== mExpReady) begin
                failures++;
                $display("[TB] FAIL random_ready[%0d] got=%b exp=%b", i, in_ready, mExpReady);
            end
            tick();
            checks++;
            if (out_valid !== mValid || out_data !== mData || out_src !== 2'(mSrc)) begin
                failures++;
                $display("[TB] FAIL random_out[%0d] got=%b/%h/%0d exp=%b/%h/%0d",
                         i, out_valid, out_data, out_src, mValid, mData, mSrc);
            end
`ifdef MUX4_ARB_BURST_EN
            checks++;
            if (out_last !== mOutLast) begin
                failures++;
                $display("[TB] FAIL random_last[%0d] got=%b exp=%b", i, out_last, mOutLast);
            end
`endif
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rotData[0] = 16'h0A0A;
        rotData[1] = 16'h1B1B;
        rotData[2] = 16'h2C2C;
        rotData[3] = 16'h3D3D;
        for (int r = 0; r < 4; r++) begin
            dataArr[r] = rotData[r];
        end
        mLast = 3; mValid = 0; mData = '0; mSrc = 0; mLocked = 0; mOutLast = 0; mGrant = -1;
        rst_n     = 1'b0;
        in_valid  = 4'b0000;
        out_ready = 1'b1;
`ifdef MUX4_ARB_BURST_EN
        in_last   = 4'b0000;
`endif
        test_reset();
        test_rotation();
        test_backpressure();
        test_wrap_skip();
        test_idle_drain();
`ifdef MUX4_ARB_BURST_EN
        test_burst();
`endif
        for (int r = 0; r < 4; r++) begin
            dataArr[r] = rotData[r];
        end
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
